// File: rtl/mtx_pkg.sv
// Shared definitions for the multi-channel frequency-hopping TX sequencer.
package mtx_pkg;

   // Sequencer states; the numeric values are visible on the state port
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_TX    = 2'd2,
      ST_GUARD = 2'd3
   } mtx_state_e;

endpackage

// File: rtl/mtx_ph_acc.sv
// Single-channel phase accumulator: clear wins over enable, wraps silently.
module mtx_ph_acc #(
   parameter int PHASE_WIDTH = 24
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr,
   input  logic                   en,
   input  logic [PHASE_WIDTH-1:0] inc,
   output logic [PHASE_WIDTH-1:0] ph
);

   logic [PHASE_WIDTH-1:0] ph_r;

   // Phase register: cleared at hop boundaries, advanced by inc on live samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ph_r <= {PHASE_WIDTH{1'b0}};
      end else if (clr) begin
         ph_r <= {PHASE_WIDTH{1'b0}};
      end else if (en) begin
         ph_r <= ph_r + inc;
      end else begin
         ph_r <= ph_r;
      end
   end

   assign ph = ph_r;

endmodule

// File: rtl/mtx_hop_seq_nch.sv
// Multi-channel frequency-hopping TX sequencer. Steps NCH phase accumulators
// through NUM_HOPS hops of NSYMB symbols x NSIG samples, with optional sync
// arming, a guard gap after every hop, one-shot/continuous frames and abort.
module mtx_hop_seq_nch
   import mtx_pkg::*;
#(
   parameter int PHASE_WIDTH   = 24,
   parameter int NCH           = 4,
   parameter int NSIG_WIDTH    = 24,
   parameter int NSIG          = 8192,
   parameter int NSYMB_WIDTH   = 16,
   parameter int NSYMB         = 16,
   parameter int NHOP_WIDTH    = 8,
   parameter int NUM_HOPS      = 4,
   parameter int GUARD_LEN     = 64,
   parameter int BASE_PH_INC   = 4096,
   parameter int HOP_PH_STEP   = 1024,
   parameter int CH_PH_SPACING = 256,
   parameter int EXT_SYNC      = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       mode_cont,
   input  logic                       sync_in,
   output logic                       valid,
   output logic [NCH*PHASE_WIDTH-1:0] ph_out,
   output logic [PHASE_WIDTH-1:0]     hop_ph_inc,
   output logic [NHOP_WIDTH-1:0]      nhop,
   output logic [NSYMB_WIDTH-1:0]     symbN,
   output logic [NSIG_WIDTH-1:0]      sigN,
   output logic [1:0]                 state,
   output logic                       hop_done,
   output logic                       frame_done,
   output logic                       sync_out
);

   localparam int GW = (GUARD_LEN > 1) ? $clog2(GUARD_LEN) : 1;
   localparam logic [NSIG_WIDTH-1:0]  SIG_LAST   = NSIG_WIDTH'(NSIG - 1);
   localparam logic [NSYMB_WIDTH-1:0] SYMB_LAST  = NSYMB_WIDTH'(NSYMB - 1);
   localparam logic [NHOP_WIDTH-1:0]  HOP_LAST   = NHOP_WIDTH'(NUM_HOPS - 1);
   localparam logic [GW-1:0]          GUARD_LAST = (GUARD_LEN > 0) ? GW'(GUARD_LEN - 1) : {GW{1'b0}};
   localparam logic [PHASE_WIDTH-1:0] BASE_INC   = PHASE_WIDTH'(BASE_PH_INC);
   localparam logic [PHASE_WIDTH-1:0] STEP_INC   = PHASE_WIDTH'(HOP_PH_STEP);

   mtx_state_e               state_r, state_s;
   logic [NSIG_WIDTH-1:0]    sig_cnt_r, sig_cnt_s;
   logic [NSYMB_WIDTH-1:0]   symb_cnt_r, symb_cnt_s;
   logic [NHOP_WIDTH-1:0]    nhop_r, nhop_s;
   logic [PHASE_WIDTH-1:0]   inc_r, inc_s;
   logic [GW-1:0]            guard_cnt_r, guard_cnt_s;
   logic                     sync_prev_r;
   logic                     valid_r, hop_done_r, frame_done_r, sync_out_r;
   logic                     hop_done_s, frame_done_s;
   logic                     acc_clr_s, acc_en_s, hop_adv_s;

   // Next-state, counter and accumulator-control decode; stop overrides everything
   always_comb begin
      state_s      = state_r;
      sig_cnt_s    = sig_cnt_r;
      symb_cnt_s   = symb_cnt_r;
      nhop_s       = nhop_r;
      inc_s        = inc_r;
      guard_cnt_s  = guard_cnt_r;
      hop_done_s   = 1'b0;
      frame_done_s = 1'b0;
      acc_clr_s    = 1'b0;
      acc_en_s     = 1'b0;
      hop_adv_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s     = (EXT_SYNC != 0) ? ST_ARM : ST_TX;
               sig_cnt_s   = {NSIG_WIDTH{1'b0}};
               symb_cnt_s  = {NSYMB_WIDTH{1'b0}};
               nhop_s      = {NHOP_WIDTH{1'b0}};
               inc_s       = BASE_INC;
               guard_cnt_s = {GW{1'b0}};
               acc_clr_s   = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (sync_in && !sync_prev_r) begin
               state_s   = ST_TX;
               acc_clr_s = 1'b1;
            end else begin
               state_s = ST_ARM;
            end
         end
         ST_TX: begin
            if ((sig_cnt_r == SIG_LAST) && (symb_cnt_r == SYMB_LAST)) begin
               // Last sample of the hop: phase is held, not advanced
               hop_done_s  = 1'b1;
               sig_cnt_s   = {NSIG_WIDTH{1'b0}};
               symb_cnt_s  = {NSYMB_WIDTH{1'b0}};
               guard_cnt_s = {GW{1'b0}};
               if (GUARD_LEN == 0) begin
                  hop_adv_s = 1'b1;
               end else begin
                  state_s = ST_GUARD;
               end
            end else begin
               acc_en_s = 1'b1;
               if (sig_cnt_r == SIG_LAST) begin
                  sig_cnt_s  = {NSIG_WIDTH{1'b0}};
                  symb_cnt_s = symb_cnt_r + NSYMB_WIDTH'(1'b1);
               end else begin
                  sig_cnt_s = sig_cnt_r + NSIG_WIDTH'(1'b1);
               end
            end
         end
         ST_GUARD: begin
            if (guard_cnt_r == GUARD_LAST) begin
               hop_adv_s = 1'b1;
            end else begin
               guard_cnt_s = guard_cnt_r + GW'(1'b1);
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Hop advance: next hop, next frame, or back to idle
      if (hop_adv_s) begin
         acc_clr_s   = 1'b1;
         guard_cnt_s = {GW{1'b0}};
         if (nhop_r != HOP_LAST) begin
            nhop_s  = nhop_r + NHOP_WIDTH'(1'b1);
            inc_s   = inc_r + STEP_INC;
            state_s = ST_TX;
         end else begin
            frame_done_s = 1'b1;
            nhop_s       = {NHOP_WIDTH{1'b0}};
            inc_s        = BASE_INC;
            state_s      = mode_cont ? ST_TX : ST_IDLE;
         end
      end else begin
         guard_cnt_s = guard_cnt_s;
      end

      // Abort: suppress any pulse due this cycle and return everything to rest
      if (stop && (state_r != ST_IDLE)) begin
         state_s      = ST_IDLE;
         sig_cnt_s    = {NSIG_WIDTH{1'b0}};
         symb_cnt_s   = {NSYMB_WIDTH{1'b0}};
         nhop_s       = {NHOP_WIDTH{1'b0}};
         inc_s        = BASE_INC;
         guard_cnt_s  = {GW{1'b0}};
         hop_done_s   = 1'b0;
         frame_done_s = 1'b0;
         acc_clr_s    = 1'b1;
         acc_en_s     = 1'b0;
      end else begin
         acc_en_s = acc_en_s;
      end
   end

   // Sequencer registers and registered status outputs derived from next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         sig_cnt_r    <= {NSIG_WIDTH{1'b0}};
         symb_cnt_r   <= {NSYMB_WIDTH{1'b0}};
         nhop_r       <= {NHOP_WIDTH{1'b0}};
         inc_r        <= BASE_INC;
         guard_cnt_r  <= {GW{1'b0}};
         sync_prev_r  <= 1'b0;
         valid_r      <= 1'b0;
         hop_done_r   <= 1'b0;
         frame_done_r <= 1'b0;
         sync_out_r   <= 1'b0;
      end else begin
         state_r      <= state_s;
         sig_cnt_r    <= sig_cnt_s;
         symb_cnt_r   <= symb_cnt_s;
         nhop_r       <= nhop_s;
         inc_r        <= inc_s;
         guard_cnt_r  <= guard_cnt_s;
         sync_prev_r  <= sync_in;
         valid_r      <= (state_s == ST_TX);
         hop_done_r   <= hop_done_s;
         frame_done_r <= frame_done_s;
         sync_out_r   <= (state_s == ST_TX) && (nhop_s == {NHOP_WIDTH{1'b0}}) &&
                         (symb_cnt_s == {NSYMB_WIDTH{1'b0}});
      end
   end

   // One accumulator per tone; channel offset is a fixed constant added to the hop increment
   genvar ch;
   generate
      for (ch = 0; ch < NCH; ch++) begin : g_ch
         localparam logic [PHASE_WIDTH-1:0] CH_OFF = PHASE_WIDTH'(ch * CH_PH_SPACING);
         logic [PHASE_WIDTH-1:0] ch_inc_s;
         assign ch_inc_s = inc_r + CH_OFF;
         mtx_ph_acc #(.PHASE_WIDTH(PHASE_WIDTH)) u_acc (
            .clk   (clk),
            .reset (reset),
            .clr   (acc_clr_s),
            .en    (acc_en_s),
            .inc   (ch_inc_s),
            .ph    (ph_out[ch*PHASE_WIDTH +: PHASE_WIDTH])
         );
      end
   endgenerate

   assign valid      = valid_r;
   assign hop_ph_inc = inc_r;
   assign nhop       = nhop_r;
   assign symbN      = symb_cnt_r;
   assign sigN       = sig_cnt_r;
   assign state      = state_r;
   assign hop_done   = hop_done_r;
   assign frame_done = frame_done_r;
   assign sync_out   = sync_out_r;

endmodule

// File: tb/tb_mtx_hop_seq_nch.sv
// Self-checking bench for mtx_hop_seq_nch: two instances (nominal base and a
// wrapping base) share stimulus and are compared against a closed-form model
// that derives every output from the cycle offset within the frame.
`timescale 1ns/1ps
module tb_mtx_hop_seq_nch;

   localparam int NSIG = 8, NSYMB = 4, NUM_HOPS = 4, GUARD = 2;
   localparam int NS = NSIG * NSYMB;
   localparam int P  = NS + GUARD;
   localparam int F  = NUM_HOPS * P;
   localparam int STEP = 1024, SPACING = 256;
   localparam logic [23:0] BASE_A = 24'd4096;
   localparam logic [23:0] BASE_B = 24'hFFFC00;

   logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, mode_cont = 1'b0, sync_in = 1'b0;
   logic        valid_a, hd_a, fd_a, so_a, valid_b, hd_b, fd_b, so_b;
   logic [47:0] ph_a, ph_b;
   logic [23:0] inc_a, inc_b, sig_a, sig_b;
   logic [7:0]  nhop_a, nhop_b;
   logic [15:0] symb_a, symb_b;
   logic [1:0]  state_a, state_b;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit valid; logic [1:0] st; logic [23:0] inc; int nhop; int symb; int sig;
      logic [23:0] ph0; logic [23:0] ph1; bit hd; bit fd; bit so;
   } exp_t;

   mtx_hop_seq_nch #(.NCH(2), .NSIG(NSIG), .NSYMB(NSYMB), .NUM_HOPS(NUM_HOPS), .GUARD_LEN(GUARD),
                     .BASE_PH_INC(4096), .HOP_PH_STEP(STEP), .CH_PH_SPACING(SPACING), .EXT_SYNC(1)) dut_a (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .mode_cont(mode_cont), .sync_in(sync_in),
      .valid(valid_a), .ph_out(ph_a), .hop_ph_inc(inc_a), .nhop(nhop_a), .symbN(symb_a), .sigN(sig_a),
      .state(state_a), .hop_done(hd_a), .frame_done(fd_a), .sync_out(so_a));

   mtx_hop_seq_nch #(.NCH(2), .NSIG(NSIG), .NSYMB(NSYMB), .NUM_HOPS(NUM_HOPS), .GUARD_LEN(GUARD),
                     .BASE_PH_INC(24'hFFFC00), .HOP_PH_STEP(STEP), .CH_PH_SPACING(SPACING), .EXT_SYNC(1)) dut_b (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .mode_cont(mode_cont), .sync_in(sync_in),
      .valid(valid_b), .ph_out(ph_b), .hop_ph_inc(inc_b), .nhop(nhop_b), .symbN(symb_b), .sigN(sig_b),
      .state(state_b), .hop_done(hd_b), .frame_done(fd_b), .sync_out(so_b));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t idle_exp(input logic [23:0] base);
      exp_t e;
      e.valid = 1'b0; e.st = 2'd0; e.inc = base; e.nhop = 0; e.symb = 0; e.sig = 0;
      e.ph0 = 24'd0; e.ph1 = 24'd0; e.hd = 1'b0; e.fd = 1'b0; e.so = 1'b0;
      return e;
   endfunction

   // Expected outputs k cycles after the first live sample of a frame
   function automatic exp_t model(input int k, input logic [23:0] base, input bit cont);
      exp_t e;
      int frame, fpos, h, r;
      logic [23:0] inc0, inc1;
      e = idle_exp(base);
      if (!cont && k >= F) begin
         e.fd = (k == F);
         return e;
      end
      frame = k / F; fpos = k % F; h = fpos / P; r = fpos % P;
      inc0 = base + 24'(h * STEP);
      inc1 = inc0 + 24'(SPACING);
      e.inc = inc0; e.nhop = h;
      e.fd = (frame > 0) && (fpos == 0);
      e.hd = (r == NS);
      if (r < NS) begin
         e.valid = 1'b1; e.st = 2'd2; e.sig = r % NSIG; e.symb = r / NSIG;
         e.ph0 = 24'(longint'(r) * longint'(inc0));
         e.ph1 = 24'(longint'(r) * longint'(inc1));
         e.so  = (h == 0) && (r < NSIG);
      end else begin
         e.st  = 2'd3;
         e.ph0 = 24'(longint'(NS - 1) * longint'(inc0));
         e.ph1 = 24'(longint'(NS - 1) * longint'(inc1));
      end
      return e;
   endfunction

   function automatic logic [125:0] pack_exp(input exp_t e);
      return {e.valid, e.st, e.inc, 8'(e.nhop), 16'(e.symb), 24'(e.sig), e.ph1, e.ph0, e.hd, e.fd, e.so};
   endfunction

   function automatic logic [125:0] obs_a();
      return {valid_a, state_a, inc_a, nhop_a, symb_a, sig_a, ph_a, hd_a, fd_a, so_a};
   endfunction

   function automatic logic [125:0] obs_b();
      return {valid_b, state_b, inc_b, nhop_b, symb_b, sig_b, ph_b, hd_b, fd_b, so_b};
   endfunction

   // Stimulus only: accept start, wait d cycles in ARM, then raise sync_in
   task automatic start_frame(input int d);
      sync_in = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < d; i++) begin
         if (i == d - 1) sync_in = 1'b1;
         tick();
      end
      sync_in = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      n_checks++;
      if (obs_a() !== pack_exp(idle_exp(BASE_A))) begin
         n_fail++; $display("FAIL reset_init got %h expected %h", obs_a(), pack_exp(idle_exp(BASE_A)));
      end
      start_frame(int'($urandom_range(1, 6)));
      n = int'($urandom_range(5, 80));
      repeat (n) tick();
      n_checks++;
      if (obs_a() !== pack_exp(model(n, BASE_A, 1'b0))) begin
         n_fail++; $display("FAIL pre_reset k=%0d got %h expected %h", n, obs_a(), pack_exp(model(n, BASE_A, 1'b0)));
      end
      #3 reset = 1'b1;
      #1;
      n_checks++;
      if (obs_a() !== pack_exp(idle_exp(BASE_A))) begin
         n_fail++; $display("FAIL reset_async_a got %h expected %h", obs_a(), pack_exp(idle_exp(BASE_A)));
      end
      n_checks++;
      if (obs_b() !== pack_exp(idle_exp(BASE_B))) begin
         n_fail++; $display("FAIL reset_async_b got %h expected %h", obs_b(), pack_exp(idle_exp(BASE_B)));
      end
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_arm_sync();
      int d;
      exp_t e;
      d = int'($urandom_range(3, 8));
      sync_in = 1'b1; tick(); sync_in = 1'b0; tick();
      n_checks++;
      if (state_a !== 2'd0) begin
         n_fail++; $display("FAIL sync_in_idle state %0d expected 0", state_a);
      end
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < d; i++) begin
         n_checks++;
         if (state_a !== 2'd1) begin
            n_fail++; $display("FAIL arm_wait i=%0d state %0d expected 1", i, state_a);
         end
         if (i == d - 1) sync_in = 1'b1;
         tick();
      end
      sync_in = 1'b0;
      for (int k = 0; k < NS; k++) begin
         e = model(k, BASE_A, 1'b0);
         n_checks++;
         if (obs_a() !== pack_exp(e)) begin
            n_fail++; $display("FAIL first_hop k=%0d got %h expected %h", k, obs_a(), pack_exp(e));
         end
         tick();
      end
      stop = 1'b1; tick(); stop = 1'b0;
      n_checks++;
      if (obs_a() !== pack_exp(idle_exp(BASE_A))) begin
         n_fail++; $display("FAIL arm_stop got %h expected %h", obs_a(), pack_exp(idle_exp(BASE_A)));
      end
   endtask

   task automatic test_full_frame();
      int hd_k[$];
      int fd_cnt, busy;
      int exp_hd[4] = '{32, 66, 100, 134};
      exp_t e;
      fd_cnt = 0; busy = 0;
      mode_cont = 1'b0;
      start_frame(int'($urandom_range(1, 6)));
      for (int k = 0; k <= F + 1; k++) begin
         e = model(k, BASE_A, 1'b0);
         n_checks++;
         if (obs_a() !== pack_exp(e)) begin
            n_fail++; $display("FAIL frame_a k=%0d got %h expected %h", k, obs_a(), pack_exp(e));
         end
         e = model(k, BASE_B, 1'b0);
         n_checks++;
         if (obs_b() !== pack_exp(e)) begin
            n_fail++; $display("FAIL frame_b k=%0d got %h expected %h", k, obs_b(), pack_exp(e));
         end
         if (hd_a) hd_k.push_back(k);
         if (fd_a) fd_cnt++;
         if (state_a >= 2'd2) busy++;
         if (k < F - 3) begin
            start   = ($urandom_range(0, 7) == 0);
            sync_in = 1'($urandom_range(0, 1));
         end else begin
            start = 1'b0; sync_in = 1'b0;
         end
         tick();
      end
      start = 1'b0; sync_in = 1'b0;
      n_checks++;
      if (hd_k.size() != 4) begin
         n_fail++; $display("FAIL hop_done_count got %0d expected 4", hd_k.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (hd_k[i] != exp_hd[i]) begin
               n_fail++; $display("FAIL hop_done_cycle %0d got %0d expected %0d", i, hd_k[i], exp_hd[i]);
            end
         end
      end
      n_checks++;
      if (fd_cnt != 1) begin
         n_fail++; $display("FAIL frame_done_count got %0d expected 1", fd_cnt);
      end
      n_checks++;
      if (busy != 136) begin
         n_fail++; $display("FAIL frame_length got %0d expected 136", busy);
      end
   endtask

   task automatic test_continuous();
      int so_cnt[3];
      exp_t e;
      so_cnt = '{0, 0, 0};
      mode_cont = 1'b1;
      start_frame(int'($urandom_range(1, 6)));
      for (int k = 0; k < 2 * F + 10; k++) begin
         e = model(k, BASE_A, 1'b1);
         n_checks++;
         if (obs_a() !== pack_exp(e)) begin
            n_fail++; $display("FAIL cont_a k=%0d got %h expected %h", k, obs_a(), pack_exp(e));
         end
         if (so_a) so_cnt[k / F]++;
         tick();
      end
      for (int f = 0; f < 2; f++) begin
         n_checks++;
         if (so_cnt[f] != NSIG) begin
            n_fail++; $display("FAIL sync_out_len frame %0d got %0d expected %0d", f, so_cnt[f], NSIG);
         end
      end
      stop = 1'b1; tick(); stop = 1'b0; mode_cont = 1'b0;
      n_checks++;
      if (obs_a() !== pack_exp(idle_exp(BASE_A))) begin
         n_fail++; $display("FAIL cont_stop got %h expected %h", obs_a(), pack_exp(idle_exp(BASE_A)));
      end
   endtask

   task automatic test_stop();
      int h, kstop;
      exp_t e;
      h = int'($urandom_range(0, NUM_HOPS - 1));
      kstop = h * P + NS - 1;
      start_frame(int'($urandom_range(1, 6)));
      for (int k = 0; k <= kstop; k++) begin
         e = model(k, BASE_A, 1'b0);
         n_checks++;
         if (obs_a() !== pack_exp(e)) begin
            n_fail++; $display("FAIL pre_stop k=%0d got %h expected %h", k, obs_a(), pack_exp(e));
         end
         start = (k == 3);
         if (k < kstop) tick();
      end
      stop = 1'b1; start = 1'b1;
      tick();
      stop = 1'b0; start = 1'b0;
      n_checks++;
      if (obs_a() !== pack_exp(idle_exp(BASE_A))) begin
         n_fail++; $display("FAIL stop_at_hop_end hop=%0d got %h expected %h", h, obs_a(), pack_exp(idle_exp(BASE_A)));
      end
      tick();
      n_checks++;
      if (obs_a() !== pack_exp(idle_exp(BASE_A))) begin
         n_fail++; $display("FAIL stop_settled got %h expected %h", obs_a(), pack_exp(idle_exp(BASE_A)));
      end
      stop = 1'b1; tick(); stop = 1'b0;
      n_checks++;
      if (obs_a() !== pack_exp(idle_exp(BASE_A))) begin
         n_fail++; $display("FAIL stop_in_idle got %h expected %h", obs_a(), pack_exp(idle_exp(BASE_A)));
      end
   endtask

   task automatic test_wrap();
      start_frame(int'($urandom_range(1, 6)));
      tick(); tick();
      n_checks++;
      if (ph_b !== {24'hFFFA00, 24'hFFF800}) begin
         n_fail++; $display("FAIL wrap_hop0_ph got %h expected %h", ph_b, {24'hFFFA00, 24'hFFF800});
      end
      repeat (P - 2) tick();
      n_checks++;
      if (inc_b !== 24'h000000) begin
         n_fail++; $display("FAIL wrap_hop1_inc got %h expected 000000", inc_b);
      end
      tick();
      n_checks++;
      if (ph_b !== {24'h000100, 24'h000000}) begin
         n_fail++; $display("FAIL wrap_hop1_ph got %h expected %h", ph_b, {24'h000100, 24'h000000});
      end
      repeat (P) tick();
      n_checks++;
      if ({inc_b, ph_b} !== {24'h000400, 24'h000500, 24'h000400}) begin
         n_fail++; $display("FAIL wrap_hop2 got %h expected %h", {inc_b, ph_b}, {24'h000400, 24'h000500, 24'h000400});
      end
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      tick();
      test_reset();
      test_arm_sync();
      test_full_frame();
      test_continuous();
      test_stop();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
